// File: rtl/t2mi_l1_sequencer.sv
// t2mi_l1_sequencer: once per T2-frame period, replays a double-buffered
// L1 signalling template as a contiguous byte burst into the T2-MI packer,
// and tracks frame / superframe indices.
// Optional feature macro: L1_FRAME_IDX_PATCH_EN (when defined, the byte at
// offset FIDX_POS of each burst is replaced by the current frame index).
module t2mi_l1_sequencer #(
    parameter int L1_LEN        = 40,
    parameter int FRAME_PERIOD  = 100000,
    parameter int FRAMES_PER_SF = 2,
    parameter int FIDX_POS      = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic       CFG_WE,
    input  logic [5:0] CFG_ADDR,
    input  logic [7:0] CFG_DATA,
    input  logic       CFG_COMMIT,
    output logic [7:0] L1_DATA,
    output logic       L1_LOAD,
    output logic [7:0] FRAME_IDX,
    output logic [3:0] SF_IDX,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam int TW = $clog2(FRAME_PERIOD);
    localparam logic [TW-1:0] T_LAST   = TW'(FRAME_PERIOD - 1);
    localparam logic [5:0]    B_LAST   = 6'(L1_LEN - 1);
    localparam logic [7:0]    F_LAST   = 8'(FRAMES_PER_SF - 1);
    localparam logic [5:0]    FIDX_IDX = 6'(FIDX_POS);
`ifdef L1_FRAME_IDX_PATCH_EN
    localparam bit PATCH_EN = 1'b1;
`else
    localparam bit PATCH_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t          state_reg;
    logic [TW-1:0]   tcnt_reg;
    logic [5:0]      bcnt_reg;
    logic            act_reg;      // which half of bank[] is the active template
    logic            pending_reg;  // commit requested, swap on next burst start

    // Both template banks in one array: address = {bank select, byte index}.
    logic [7:0]      bank [0:127];

    logic            tick;
    logic            start;
    logic            last;
    logic            rd_sel;
    logic [5:0]      rd_idx;
    logic [6:0]      rd_addr;
    logic            patch_hit;

    assign tick    = ENABLE && (tcnt_reg == T_LAST);
    assign start   = tick && (state_reg == IDLE);
    assign last    = (state_reg == LOAD) && (bcnt_reg == B_LAST);
    assign rd_addr = {rd_sel, rd_idx};
    assign patch_hit = PATCH_EN && (rd_idx == FIDX_IDX);

    // Address of the byte to present next: byte 0 of the (possibly freshly
    // swapped) bank at burst start, otherwise the following byte.
    always_comb begin
        rd_sel = act_reg;
        rd_idx = bcnt_reg + 6'd1;
        if (state_reg == IDLE) begin
            rd_sel = act_reg ^ pending_reg;
            rd_idx = 6'd0;
        end
    end

    // Control-side writes land in the shadow bank only; out-of-range ignored.
    always_ff @(posedge CLK) begin
        if (CFG_WE && ({1'b0, CFG_ADDR} < 7'(L1_LEN))) begin
            bank[{~act_reg, CFG_ADDR}] <= CFG_DATA;
        end
    end

    // Frame timer, commit/swap bookkeeping, burst FSM and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            tcnt_reg    <= '0;
            bcnt_reg    <= '0;
            act_reg     <= 1'b0;
            pending_reg <= 1'b0;
            L1_DATA     <= 8'd0;
            L1_LOAD     <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_IDX   <= 8'd0;
            SF_IDX      <= 4'd0;
            OVERRUN     <= 1'b0;
        end else begin
            if (!ENABLE || (tcnt_reg == T_LAST)) begin
                tcnt_reg <= '0;
            end else begin
                tcnt_reg <= tcnt_reg + 1'b1;
            end

            // A tick that lands inside a burst is dropped but remembered.
            if (tick && (state_reg == LOAD)) begin
                OVERRUN <= 1'b1;
            end

            // A commit arriving in the start cycle itself waits for the next burst.
            if (start) begin
                pending_reg <= CFG_COMMIT;
            end else if (CFG_COMMIT) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        act_reg   <= act_reg ^ pending_reg;
                        state_reg <= LOAD;
                        bcnt_reg  <= 6'd0;
                        L1_DATA   <= patch_hit ? FRAME_IDX : bank[rd_addr];
                        L1_LOAD   <= 1'b1;
                        BUSY      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (last) begin
                        state_reg <= IDLE;
                        bcnt_reg  <= 6'd0;
                        L1_DATA   <= 8'd0;
                        L1_LOAD   <= 1'b0;
                        BUSY      <= 1'b0;
                        if (FRAME_IDX == F_LAST) begin
                            FRAME_IDX <= 8'd0;
                            SF_IDX    <= SF_IDX + 4'd1;
                        end else begin
                            FRAME_IDX <= FRAME_IDX + 8'd1;
                        end
                    end else begin
                        bcnt_reg <= bcnt_reg + 6'd1;
                        L1_DATA  <= patch_hit ? FRAME_IDX : bank[rd_addr];
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
